mult_arbiter: RTL

Two-port front-end for the shared iterative signed multiplier (32x32 -> 64, radix-16, one nibble of the multiplier per clock). It arbitrates round-robin between two requesters, latches the winning operands and drives the multiplier's begin/operand inputs. It holds operands stable, captures the product on `mult_end` and returns it on a per-port valid/ready response channel. A watchdog aborts any operation that fails to finish within TIMEOUT cycles.

---
 rtl/mult_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: two-port round-robin front-end for the shared iterative
// signed multiplier. Latches the winning operands, drives the multiplier's
// begin/operand inputs, captures the product (or aborts on a watchdog
// timeout) and returns the result on a per-port valid/ready channel.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req{0,1}_valid/ready           request handshake per port
//   req{0,1}_op1/op2               32-bit signed operands per port
//   resp{0,1}_valid/ready          response handshake per port
//   resp_product, resp_timeout     shared result payload
//   busy                           high whenever not idle
//   mult_begin, mult_op1/op2       registered drive to the multiplier
//   mult_product, mult_end         result from the multiplier
module mult_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req0_op2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req1_op2,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [63:0] resp_product,
    output logic        resp_timeout,
    output logic        busy,
    output logic        mult_begin,
    output logic [31:0] mult_op1,
    output logic [31:0] mult_op2,
    input  logic [63:0] mult_product,
    input  logic        mult_end
);

    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OP_W-1:0]     op1_d, op2_d;
    logic [PROD_W-1:0]   product_d;
    logic                timeout_d;
    logic                begin_d;
    logic                resp0_valid_d, resp1_valid_d;
    logic                busy_d;
    logic                win1;

    // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
    assign win1 = req1_valid && (!req0_valid || !last_grant_q);

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mult_op1     <= '0;
            mult_op2     <= '0;
            resp_product <= '0;
            resp_timeout <= 1'b0;
            mult_begin   <= 1'b0;
            resp0_valid  <= 1'b0;
            resp1_valid  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mult_op1     <= op1_d;
            mult_op2     <= op2_d;
            resp_product <= product_d;
            resp_timeout <= timeout_d;
            mult_begin   <= begin_d;
            resp0_valid  <= resp0_valid_d;
            resp1_valid  <= resp1_valid_d;
            busy         <= busy_d;
        end
    end

    // Next-state, next-output and combinational request readies.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op1_d        = mult_op1;
        op2_d        = mult_op2;
        product_d    = resp_product;
        timeout_d    = resp_timeout;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready   = !rst && !win1;
                    req1_ready   = !rst && win1;
                    grant_d      = win1;
                    last_grant_d = win1;
                    cnt_d        = '0;
                    op1_d        = win1 ? req1_op1 : req0_op1;
                    op2_d        = win1 ? req1_op2 : req0_op2;
                    state_d      = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A finishing product beats the watchdog in the same cycle.
                if (mult_end) begin
                    product_d = mult_product;
                    timeout_d = 1'b0;
                    state_d   = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    product_d = '0;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (grant_q ? resp1_ready : resp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs follow the state being entered, so begin drops as RESP starts.
        begin_d       = (state_d == RUN);
        resp0_valid_d = (state_d == RESP) && !grant_d;
        resp1_valid_d = (state_d == RESP) && grant_d;
        busy_d        = (state_d != IDLE);
    end

endmodule
